// File: rtl/onewire_byte_ctl_if.sv
// Host command/response stream and onewire bit-engine Avalon MM slave
// signals of onewire_byte_ctl, grouped as one bundle.
// slave  : the byte sequencer (onewire_byte_ctl).
// master : the surroundings (host plus bit engine, e.g. a testbench).
interface onewire_byte_ctl_if;
    // host command stream
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_od;
    logic [7:0]  cmd_data;
    // host response stream
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_presence;
    logic        rsp_err;
    // bit engine Avalon MM slave
    logic        bit_write;
    logic [31:0] bit_writedata;
    logic        bit_read;
    logic [31:0] bit_readdata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_od, cmd_data, rsp_ready, bit_readdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err,
               bit_write, bit_writedata, bit_read
    );

    modport master (
        output cmd_valid, cmd_op, cmd_od, cmd_data, rsp_ready, bit_readdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err,
               bit_write, bit_writedata, bit_read
    );
endinterface

// File: rtl/onewire_byte_ctl.sv
// onewire_byte_ctl: byte-level sequencer between a host command stream and
// the onewire bit engine. Each command (reset, write byte, read byte,
// single bit) becomes a series of bit slots: write {dtx,rst,od}, wait for
// stx, sample drx, clear stx by a read. One response per command.
// Optional per-slot watchdog: define ONEWIRE_BYTE_CTL_TIMEOUT_EN.
module onewire_byte_ctl #(
    parameter int TMO = 4096,
    parameter int TMW = $clog2(TMO + 1)
) (
    input  logic               clk,
    input  logic               rst,
    onewire_byte_ctl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_BIT   = 2'b11;

    state_t      state;
    logic [1:0]  op;
    logic        od;
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic [2:0]  cnt;
    logic        presence;
    logic        wait_armed;

    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_presence_q;
    logic        rsp_err_q;
    logic        bit_write_q;
    logic [31:0] bit_writedata_q;
    logic        bit_read_q;

    logic        stx;
    logic        drx;

    assign stx = bus.bit_readdata[4];
    assign drx = bus.bit_readdata[3];

    // srx and the echoed control bits are not needed for sequencing
    logic unused_rd;
    assign unused_rd = ^{bus.bit_readdata[31:5], bus.bit_readdata[2:0]};

`ifdef ONEWIRE_BYTE_CTL_TIMEOUT_EN
    localparam logic [TMW-1:0] TMO_LAST = TMW'(TMO - 1);
    logic [TMW-1:0] tmo_cnt;
`else
    // watchdog parameters have no effect when the watchdog is compiled out
    logic [TMW-1:0] unused_tmo;
    assign unused_tmo = TMW'(TMO);
`endif

    // Slot control word {dtx, rst, od}: reset pulse, read slot (release
    // line, dtx 1) or write slot carrying the current data bit.
    function automatic logic [31:0] slot_word(input logic [1:0] f_op,
                                              input logic       f_od,
                                              input logic       f_bit);
        logic [31:0] w;
        case (f_op)
            2'b00:   w = {29'd0, 1'b0,  1'b1, f_od};
            2'b10:   w = {29'd0, 1'b1,  1'b0, f_od};
            default: w = {29'd0, f_bit, 1'b0, f_od};
        endcase
        return w;
    endfunction

    // Sequencer FSM with all host and bit-engine outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            op              <= 2'b00;
            od              <= 1'b0;
            tx              <= 8'h00;
            rx              <= 8'h00;
            cnt             <= 3'd0;
            presence        <= 1'b0;
            wait_armed      <= 1'b0;
            cmd_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= 8'h00;
            rsp_presence_q  <= 1'b0;
            rsp_err_q       <= 1'b0;
            bit_write_q     <= 1'b0;
            bit_writedata_q <= 32'd0;
            bit_read_q      <= 1'b0;
`ifdef ONEWIRE_BYTE_CTL_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block based on the values from before the clock edge.
            case (state)
                S_IDLE: begin
                    if (cmd_ready_q && bus.cmd_valid) begin
                        op              <= bus.cmd_op;
                        od              <= bus.cmd_od;
                        tx              <= bus.cmd_data;
                        rx              <= 8'h00;
                        presence        <= 1'b0;
                        cnt             <= (bus.cmd_op[0] ^ bus.cmd_op[1]) ? 3'd7 : 3'd0;
                        cmd_ready_q     <= 1'b0;
                        bit_write_q     <= 1'b1;
                        bit_writedata_q <= slot_word(bus.cmd_op, bus.cmd_od, bus.cmd_data[0]);
                        state           <= S_ISSUE;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    bit_write_q <= 1'b0;
                    wait_armed  <= 1'b0;
`ifdef ONEWIRE_BYTE_CTL_TIMEOUT_EN
                    tmo_cnt     <= '0;
`endif
                    state       <= S_WAIT;
                end

                S_WAIT: begin
                    // the first WAIT cycle may still show the previous stx
                    wait_armed <= 1'b1;
                    if (wait_armed && stx) begin
                        case (op)
                            OP_RESET: presence <= ~drx;
                            OP_BIT:   rx       <= {7'd0, drx};
                            default:  rx       <= {drx, rx[7:1]};
                        endcase
                        bit_read_q <= 1'b1;
                        state      <= S_ACK;
                    end
`ifdef ONEWIRE_BYTE_CTL_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_data_q     <= rx;
                        rsp_presence_q <= 1'b0;
                        rsp_err_q      <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                S_ACK: begin
                    bit_read_q <= 1'b0;
                    tx         <= {1'b0, tx[7:1]};
                    if (cnt == 3'd0) begin
                        rsp_valid_q    <= 1'b1;
                        rsp_data_q     <= rx;
                        rsp_presence_q <= presence;
                        state          <= S_RESP;
                    end else begin
                        cnt             <= cnt - 3'd1;
                        bit_write_q     <= 1'b1;
                        bit_writedata_q <= slot_word(op, od, tx[1]);
                        state           <= S_ISSUE;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q    <= 1'b0;
                        rsp_data_q     <= 8'h00;
                        rsp_presence_q <= 1'b0;
                        rsp_err_q      <= 1'b0;
                        cmd_ready_q    <= 1'b1;
                        state          <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_presence  = rsp_presence_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.bit_write     = bit_write_q;
    assign bus.bit_writedata = bit_writedata_q;
    assign bus.bit_read      = bit_read_q;

endmodule
